note_voice: RTL and testbench

NOTE_VOICE -- requirements
Module: note_voice

---
 rtl/note_voice.sv | 161 ++++++++++++++++
 tb/tb_note_voice.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_voice.sv
// Square-wave note voice with an ADSR-style (attack/sustain/release) envelope.
// Four prioritised gates pick the note; all state advances on sample_tick only.
module note_voice #(
  parameter logic [15:0] HALF0        = 16'd109,
  parameter logic [15:0] HALF1        = 16'd97,
  parameter logic [15:0] HALF2        = 16'd87,
  parameter logic [15:0] HALF3        = 16'd73,
  parameter logic [14:0] ATTACK_STEP  = 15'd64,
  parameter logic [14:0] RELEASE_STEP = 15'd32,
  parameter logic [14:0] AMP_MAX      = 15'd16384
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Enable,
  input  logic        gate0,
  input  logic        gate1,
  input  logic        gate2,
  input  logic        gate3,
  input  logic        sample_tick,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        active
);

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } env_state_t;

  localparam logic [14:0] AMP_FIRST = (ATTACK_STEP > AMP_MAX) ? AMP_MAX : ATTACK_STEP;

  env_state_t  state, state_next;
  logic [14:0] amp, amp_next;
  logic [15:0] phase, phase_next;
  logic        pol, pol_next;        // 0 = positive half-cycle
  logic [1:0]  note_idx, note_next;

  logic        gate_on;
  logic [1:0]  sel_idx;
  logic        note_change;
  logic [15:0] half_sel, half_eff;
  logic [15:0] amp_up_w, amp_dn_w;
  logic [14:0] amp_up, amp_dn;
  logic [15:0] amp_ext;
  logic [15:0] sample_next;

  // Gate decode and saturating envelope arithmetic
  always_comb begin
    gate_on = Enable & (gate0 | gate1 | gate2 | gate3);
    if (gate0)      sel_idx = 2'd0;
    else if (gate1) sel_idx = 2'd1;
    else if (gate2) sel_idx = 2'd2;
    else            sel_idx = 2'd3;

    amp_up_w = {1'b0, amp} + {1'b0, ATTACK_STEP};
    amp_up   = (amp_up_w > {1'b0, AMP_MAX}) ? AMP_MAX : amp_up_w[14:0];
    amp_dn_w = {1'b0, amp} - {1'b0, RELEASE_STEP};
    amp_dn   = amp_dn_w[15] ? '0 : amp_dn_w[14:0];
  end

  // Envelope next-state
  always_comb begin
    state_next = state;
    amp_next   = amp;
    case (state)
      IDLE: begin
        if (gate_on) begin
          state_next = ATTACK;
          amp_next   = AMP_FIRST;
        end else begin
          amp_next   = '0;
        end
      end
      ATTACK: begin
        if (gate_on) begin
          amp_next = amp_up;
          if (amp_up == AMP_MAX) state_next = SUSTAIN;
        end else begin
          amp_next   = amp_dn;
          state_next = RELEASE;
        end
      end
      SUSTAIN: begin
        if (gate_on) begin
          amp_next = AMP_MAX;
        end else begin
          amp_next   = amp_dn;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (gate_on) begin
          amp_next   = amp_up;
          state_next = ATTACK;
        end else begin
          amp_next = amp_dn;
          if (amp_dn == '0) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        amp_next   = '0;
      end
    endcase
  end

  // Oscillator next-state; a note switch only restarts the phase once sounding
  always_comb begin
    note_next = gate_on ? sel_idx : note_idx;
    case (note_next)
      2'd0:    half_sel = HALF0;
      2'd1:    half_sel = HALF1;
      2'd2:    half_sel = HALF2;
      default: half_sel = HALF3;
    endcase
    half_eff    = (half_sel == '0) ? 16'd1 : half_sel;
    note_change = gate_on && (state != IDLE) && (sel_idx != note_idx);

    phase_next = phase + 16'd1;
    pol_next   = pol;
    if (state_next == IDLE || note_change) begin
      phase_next = '0;
      pol_next   = 1'b0;
    end else if (phase == half_eff - 16'd1) begin
      phase_next = '0;
      pol_next   = ~pol;
    end

    amp_ext     = {1'b0, amp_next};
    sample_next = '0;
    if (state_next != IDLE)
      sample_next = pol_next ? (~amp_ext + 16'd1) : amp_ext;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      amp          <= '0;
      phase        <= '0;
      pol          <= 1'b0;
      note_idx     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= sample_tick;
      if (sample_tick) begin
        state      <= state_next;
        amp        <= amp_next;
        phase      <= phase_next;
        pol        <= pol_next;
        note_idx   <= note_next;
        sample_out <= sample_next;
      end
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_note_voice.sv
// Bench for note_voice: fixed vector table, hand-written corner sequences and
// randomized gate traffic checked against an arithmetic envelope/oscillator model.
module tb_note_voice;

  localparam int P_H0 = 2, P_H1 = 3, P_H2 = 0, P_H3 = 5;
  localparam int P_ATT = 1000, P_REL = 1500, P_MAX = 3000;
  localparam int S_IDLE = 0, S_ATT = 1, S_SUS = 2, S_REL = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Enable;
  logic        gate0, gate1, gate2, gate3;
  logic        sample_tick;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        active;

  int n_checks = 0;
  int n_errors = 0;

  // model state: stage, amplitude, oscillator steps since phase origin, note
  int m_stage, m_amp, m_k, m_note;

  typedef struct {
    logic       en;
    logic [3:0] g;
    int         exp_s;
    int         exp_act;
  } vec_t;

  vec_t vecs[$];

  note_voice #(
    .HALF0       (16'd2),
    .HALF1       (16'd3),
    .HALF2       (16'd0),
    .HALF3       (16'd5),
    .ATTACK_STEP (15'd1000),
    .RELEASE_STEP(15'd1500),
    .AMP_MAX     (15'd3000)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .Enable      (Enable),
    .gate0       (gate0),
    .gate1       (gate1),
    .gate2       (gate2),
    .gate3       (gate3),
    .sample_tick (sample_tick),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .active      (active)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int half_of(input int n);
    int h;
    case (n)
      0:       h = P_H0;
      1:       h = P_H1;
      2:       h = P_H2;
      default: h = P_H3;
    endcase
    return (h == 0) ? 1 : h;
  endfunction

  function automatic int m_sample();
    if (m_stage == S_IDLE) return 0;
    return (((m_k / half_of(m_note)) % 2) == 1) ? -m_amp : m_amp;
  endfunction

  function automatic int m_active();
    return (m_stage != S_IDLE) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_stage = S_IDLE;
    m_amp   = 0;
    m_k     = 0;
    m_note  = 0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] g);
    bit on;
    int sel;
    int prev;
    on   = en && (g != 4'b0000);
    sel  = g[0] ? 0 : g[1] ? 1 : g[2] ? 2 : 3;
    prev = m_stage;
    case (m_stage)
      S_IDLE: begin
        if (on) begin
          m_stage = S_ATT;
          m_amp   = imin(P_ATT, P_MAX);
        end
      end
      S_ATT, S_SUS: begin
        if (on) begin
          m_amp = (m_stage == S_SUS) ? P_MAX : imin(m_amp + P_ATT, P_MAX);
          if (m_amp == P_MAX) m_stage = S_SUS;
        end else begin
          m_amp   = imax(m_amp - P_REL, 0);
          m_stage = S_REL;
        end
      end
      default: begin
        if (on) begin
          m_amp   = imin(m_amp + P_ATT, P_MAX);
          m_stage = S_ATT;
        end else begin
          m_amp = imax(m_amp - P_REL, 0);
          if (m_amp == 0) m_stage = S_IDLE;
        end
      end
    endcase
    if (m_stage == S_IDLE) begin
      m_k = 0;
    end else if (prev == S_IDLE) begin
      m_note = sel;
      m_k    = 1;
    end else if (on && sel != m_note) begin
      m_note = sel;
      m_k    = 0;
    end else begin
      m_k++;
    end
  endtask

  // Called at a falling edge; issues one tick and returns at the fourth falling edge.
  task automatic do_tick(input logic en, input logic [3:0] g, output int s, output int act);
    Enable = en;
    {gate3, gate2, gate1, gate0} = g;
    sample_tick = 1'b1;
    @(negedge CLK);
    sample_tick = 1'b0;
    s   = int'($signed(sample_out));
    act = int'(active);
    chk("valid_hi", int'(sample_valid), 1);
    model_step(en, g);
    @(negedge CLK);
    chk("valid_lo", int'(sample_valid), 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b1;
    sample_tick = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  function automatic vec_t mkv(input logic en, input logic [3:0] g, input int s, input int a);
    vec_t v;
    v.en = en; v.g = g; v.exp_s = s; v.exp_act = a;
    return v;
  endfunction

  initial begin
    int s, a;
    logic [3:0] rg;
    logic ren;
    int exp_a[6];
    int exp_b[5];

    RESET = 1'b1; Enable = 1'b0; sample_tick = 1'b0;
    {gate3, gate2, gate1, gate0} = 4'b0000;
    model_reset();
    #1;
    chk("rst_sample", int'(sample_out), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_active", int'(active), 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // disabled, attack/square, release, retrigger, HALF=0 note, HALF=5 note, release
    vecs.push_back(mkv(1'b0, 4'b0001,     0, 0));
    vecs.push_back(mkv(1'b0, 4'b1111,     0, 0));
    vecs.push_back(mkv(1'b1, 4'b0001,  1000, 1));
    vecs.push_back(mkv(1'b1, 4'b0001, -2000, 1));
    vecs.push_back(mkv(1'b1, 4'b0001, -3000, 1));
    vecs.push_back(mkv(1'b1, 4'b0001,  3000, 1));
    vecs.push_back(mkv(1'b1, 4'b0001,  3000, 1));
    vecs.push_back(mkv(1'b1, 4'b0001, -3000, 1));
    vecs.push_back(mkv(1'b1, 4'b0000, -1500, 1));
    vecs.push_back(mkv(1'b1, 4'b0000,     0, 0));
    vecs.push_back(mkv(1'b1, 4'b0000,     0, 0));
    vecs.push_back(mkv(1'b1, 4'b0001,  1000, 1));
    vecs.push_back(mkv(1'b1, 4'b0001, -2000, 1));
    vecs.push_back(mkv(1'b1, 4'b0001, -3000, 1));
    vecs.push_back(mkv(1'b0, 4'b0001,  1500, 1));
    vecs.push_back(mkv(1'b1, 4'b0001,  2500, 1));
    vecs.push_back(mkv(1'b1, 4'b0001, -3000, 1));
    vecs.push_back(mkv(1'b1, 4'b0100,  3000, 1));
    vecs.push_back(mkv(1'b1, 4'b0100, -3000, 1));
    vecs.push_back(mkv(1'b1, 4'b0100,  3000, 1));
    vecs.push_back(mkv(1'b1, 4'b1000,  3000, 1));
    vecs.push_back(mkv(1'b1, 4'b1000,  3000, 1));
    vecs.push_back(mkv(1'b1, 4'b0000,  1500, 1));
    vecs.push_back(mkv(1'b1, 4'b0000,     0, 0));

    @(negedge CLK);
    foreach (vecs[i]) begin
      do_tick(vecs[i].en, vecs[i].g, s, a);
      chk($sformatf("vec%0d_sample", i), s, vecs[i].exp_s);
      chk($sformatf("vec%0d_active", i), a, vecs[i].exp_act);
    end

    // asynchronous reset landing between clock edges while a sample is live
    do_tick(1'b1, 4'b0001, s, a);
    do_tick(1'b1, 4'b0001, s, a);
    sample_tick = 1'b1;
    @(posedge CLK);
    #1;
    sample_tick = 1'b0;
    chk("async_pre_valid", int'(sample_valid), 1);
    chk("async_pre_sample", int'($signed(sample_out)), -3000);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_sample", int'(sample_out), 0);
    chk("async_valid", int'(sample_valid), 0);
    chk("async_active", int'(active), 0);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();

    // priority gate1 over gate3 (period 6), then gate0 takes over (period 4)
    exp_a = '{1000, 2000, -3000, -3000, -3000, 3000};
    exp_b = '{3000, 3000, -3000, -3000, 3000};
    foreach (exp_a[i]) begin
      do_tick(1'b1, 4'b1010, s, a);
      chk($sformatf("prio_a%0d", i), s, exp_a[i]);
    end
    foreach (exp_b[i]) begin
      do_tick(1'b1, 4'b1011, s, a);
      chk($sformatf("prio_b%0d", i), s, exp_b[i]);
    end

    // reset pulse mid-attack, gate held throughout
    apply_reset();
    do_tick(1'b1, 4'b0001, s, a);
    chk("rma_first", s, 1000);
    RESET = 1'b1;
    #3;
    chk("rma_active", int'(active), 0);
    chk("rma_sample", int'(sample_out), 0);
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    do_tick(1'b1, 4'b0001, s, a);
    chk("rma_restart", s, 1000);
    chk("rma_restart_act", a, 1);

    // randomized traffic against the model
    apply_reset();
    rg = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) apply_reset();
      if ($urandom_range(0, 5) == 0)
        rg = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      ren = ($urandom_range(0, 11) != 0);
      do_tick(ren, rg, s, a);
      chk($sformatf("rand%0d_sample", i), s, m_sample());
      chk($sformatf("rand%0d_active", i), a, m_active());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
